// File: rtl/proc_run_ctrl.sv
// Run sequencer: parks the processor in reset, loads start PC, runs to end_pc/stall/watchdog (option: PC_STALL_DETECT_EN).
// Latency: proc_resetl rises RESET_CYCLES+1 edges after an accepted start; start is dropped, not queued, while busy.
module proc_run_ctrl #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RESET_CYCLES = 2,
    parameter int WDOG_W       = 16,
    parameter int WDOG_LIMIT   = 255,
    parameter int STALL_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] end_pc,
    input  logic [DATA_W-1:0] expected,
    input  logic [ADDR_W-1:0] proc_currentpc,
    input  logic [DATA_W-1:0] proc_memtoreg,
    output logic              proc_resetl,
    output logic [ADDR_W-1:0] proc_startpc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              halted,
    output logic [DATA_W-1:0] result,
    output logic [WDOG_W-1:0] cycle_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, DONE, TIMEOUT} state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [ADDR_W-1:0] end_pc_q, end_pc_nxt;
    logic [DATA_W-1:0] expected_q, expected_nxt;
    logic [ADDR_W-1:0] startpc_nxt;
    logic              resetl_nxt, busy_nxt, done_nxt, pass_nxt, timeout_nxt, halted_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic [WDOG_W-1:0] count_nxt;
    logic              end_hit;
    logic              stall;

    assign end_hit = (proc_currentpc >= end_pc_q);

`ifdef PC_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    logic [ADDR_W-1:0]  last_pc;
    logic               pc_seen;
    logic [STALL_W-1:0] rep_cnt, rep_cnt_nxt;

    // The first RUN cycle has no previous PC, so it can never count as a repeat.
    always_comb begin
        rep_cnt_nxt = '0;
        if (pc_seen && (proc_currentpc == last_pc))
            rep_cnt_nxt = rep_cnt + 1'b1;
    end

    assign stall = (rep_cnt_nxt == STALL_W'(STALL_CYCLES));

    always_ff @(posedge CLK) begin
        if (reset || (state != RUN)) begin
            last_pc <= '0;
            pc_seen <= 1'b0;
            rep_cnt <= '0;
        end else begin
            last_pc <= proc_currentpc;
            pc_seen <= 1'b1;
            rep_cnt <= rep_cnt_nxt;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        end_pc_nxt   = end_pc_q;
        expected_nxt = expected_q;
        startpc_nxt  = proc_startpc;
        resetl_nxt   = proc_resetl;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        timeout_nxt  = timeout;
        halted_nxt   = halted;
        result_nxt   = result;
        count_nxt    = cycle_count;

        case (state)
            IDLE, DONE, TIMEOUT: begin
                resetl_nxt = 1'b0;
                if (start) begin
                    state_nxt    = RESET_HOLD;
                    hold_cnt_nxt = '0;
                    startpc_nxt  = start_pc;
                    end_pc_nxt   = end_pc;
                    expected_nxt = expected;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                    timeout_nxt  = 1'b0;
                    halted_nxt   = 1'b0;
                    result_nxt   = '0;
                    count_nxt    = '0;
                end
            end
            RESET_HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES)) begin
                    state_nxt  = RUN;
                    resetl_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                // End address outranks both stall and watchdog on the same cycle.
                if (end_hit || stall) begin
                    state_nxt  = DONE;
                    resetl_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    halted_nxt = ~end_hit;
                    result_nxt = proc_memtoreg;
                    pass_nxt   = (proc_memtoreg == expected_q);
                end else if (cycle_count == WDOG_W'(WDOG_LIMIT - 1)) begin
                    state_nxt   = TIMEOUT;
                    resetl_nxt  = 1'b0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    pass_nxt    = 1'b0;
                    result_nxt  = proc_memtoreg;
                end else begin
                    count_nxt = cycle_count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            end_pc_q     <= '0;
            expected_q   <= '0;
            proc_startpc <= '0;
            proc_resetl  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            halted       <= 1'b0;
            result       <= '0;
            cycle_count  <= '0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            end_pc_q     <= end_pc_nxt;
            expected_q   <= expected_nxt;
            proc_startpc <= startpc_nxt;
            proc_resetl  <= resetl_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            timeout      <= timeout_nxt;
            halted       <= halted_nxt;
            result       <= result_nxt;
            cycle_count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed runs against a stand-in processor, a run-age model checked every cycle, plus literal checks.
module tb_proc_run_ctrl;
    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int RESET_CYCLES = 2;
    localparam int WDOG_W       = 16;
    localparam int WDOG_LIMIT   = 255;
    localparam int STALL_CYCLES = 4;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_pc = '0;
    logic [ADDR_W-1:0] end_pc = '0;
    logic [DATA_W-1:0] expected = '0;
    logic [ADDR_W-1:0] pc = '0;
    logic [DATA_W-1:0] memtoreg;
    logic              proc_resetl;
    logic [ADDR_W-1:0] proc_startpc;
    logic              busy, done, pass, timeout, halted;
    logic [DATA_W-1:0] result;
    logic [WDOG_W-1:0] cycle_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Stand-in processor: PC advances by pc_step; memtoreg returns hit_val once PC reaches hit_pc.
    logic [63:0] pc_step = 64'd4;
    logic [63:0] hit_pc  = '1;
    logic [63:0] hit_val = '0;
    logic        rl_smp;
    logic [63:0] spc_smp;

    assign memtoreg = (pc >= hit_pc) ? hit_val : {pc[31:0], 32'h0};

    proc_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_CYCLES(RESET_CYCLES),
        .WDOG_W(WDOG_W), .WDOG_LIMIT(WDOG_LIMIT), .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .expected(expected), .proc_currentpc(pc), .proc_memtoreg(memtoreg),
        .proc_resetl(proc_resetl), .proc_startpc(proc_startpc), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .halted(halted), .result(result), .cycle_count(cycle_count)
    );

    always #5 CLK = ~CLK;

    // Processor register: loads startpc while held in reset, steps once released.
    always begin
        @(posedge CLK);
        rl_smp  = proc_resetl;
        spc_smp = proc_startpc;
        @(negedge CLK);
        if (rl_smp !== 1'b1) pc = spc_smp;
        else                 pc = pc + pc_step;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a run is described by its age in edges since the accepting start edge.
    bit          m_active = 0;
    int          m_age = 0;
    int          m_same = 0;
    bit          m_havepc = 0;
    bit          m_stall;
    logic [63:0] m_prev = '0, m_epc = '0, m_exp = '0;
    logic        m_resetl = 0, m_busy = 0, m_done = 0, m_pass = 0, m_timeout = 0, m_halted = 0;
    logic [63:0] m_startpc = '0, m_result = '0;
    int          m_cc = 0;

    always begin
        @(posedge CLK);
        if (reset) begin
            m_active = 0; m_resetl = 0; m_startpc = '0; m_busy = 0; m_done = 0;
            m_pass = 0; m_timeout = 0; m_halted = 0; m_result = '0; m_cc = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age == RESET_CYCLES + 1) begin
                m_resetl = 1;
            end else if (m_age > RESET_CYCLES + 1) begin
                m_stall = 0;
`ifdef PC_STALL_DETECT_EN
                if (m_havepc && pc == m_prev) m_same++;
                else                          m_same = 0;
                m_prev   = pc;
                m_havepc = 1;
                m_stall  = (m_same >= STALL_CYCLES);
`endif
                if (pc >= m_epc || m_stall) begin
                    m_active = 0; m_resetl = 0; m_busy = 0; m_done = 1;
                    m_halted = !(pc >= m_epc);
                    m_result = memtoreg;
                    m_pass   = (memtoreg == m_exp);
                end else if (m_cc == WDOG_LIMIT - 1) begin
                    m_active = 0; m_resetl = 0; m_busy = 0; m_done = 1;
                    m_timeout = 1; m_pass = 0; m_result = memtoreg;
                end else begin
                    m_cc++;
                end
            end
        end else if (start) begin
            m_active = 1; m_age = 0; m_same = 0; m_havepc = 0;
            m_startpc = start_pc; m_epc = end_pc; m_exp = expected;
            m_resetl = 0; m_busy = 1; m_done = 0; m_pass = 0; m_timeout = 0;
            m_halted = 0; m_result = '0; m_cc = 0;
        end
        #1;
        if (chk_en) begin
            check("proc_resetl", {63'd0, proc_resetl}, {63'd0, m_resetl});
            check("proc_startpc", proc_startpc, m_startpc);
            check("busy", {63'd0, busy}, {63'd0, m_busy});
            check("done", {63'd0, done}, {63'd0, m_done});
            check("pass", {63'd0, pass}, {63'd0, m_pass});
            check("timeout", {63'd0, timeout}, {63'd0, m_timeout});
            check("halted", {63'd0, halted}, {63'd0, m_halted});
            check("result", result, m_result);
            check("cycle_count", {48'd0, cycle_count}, 64'(m_cc));
        end
    end

    task automatic do_start(input logic [63:0] spc, input logic [63:0] epc, input logic [63:0] exp,
                            input logic [63:0] step, input logic [63:0] hpc, input logic [63:0] hval);
        @(negedge CLK);
        pc_step = step; hit_pc = hpc; hit_val = hval;
        start_pc = spc; end_pc = epc; expected = exp; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 600) begin
            @(negedge CLK);
            n++;
        end
        check(name, {63'd0, done}, 64'd1);
    endtask

    task automatic check_end(input string tag, input logic p, input logic t, input logic h,
                             input logic [63:0] res, input int cc);
        check({tag, "_pass"}, {63'd0, pass}, {63'd0, p});
        check({tag, "_timeout"}, {63'd0, timeout}, {63'd0, t});
        check({tag, "_halted"}, {63'd0, halted}, {63'd0, h});
        check({tag, "_result"}, result, res);
        check({tag, "_cycles"}, {48'd0, cycle_count}, 64'(cc));
        check({tag, "_resetl"}, {63'd0, proc_resetl}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_resetl", {63'd0, proc_resetl}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cycles", {48'd0, cycle_count}, 64'd0);

        // T1: 0x00 -> 0x30 in steps of 4, 12 non-terminating RUN cycles, matching result
        do_start(64'h0, 64'h30, 64'hF, 64'd4, 64'h30, 64'hF);
        wait_done("t1_done");
        check_end("t1", 1'b1, 1'b0, 1'b0, 64'hF, 12);

        // T2: restart straight from DONE, wrong result
        do_start(64'h0, 64'h30, 64'hF, 64'd4, 64'h30, 64'hE);
        wait_done("t2_done");
        check_end("t2", 1'b0, 1'b0, 1'b0, 64'hE, 12);

        // T3: end never reached, watchdog fires at PC 0x3F8
        do_start(64'h0, 64'h10000, 64'h1, 64'd4, '1, 64'h0);
        wait_done("t3_done");
        check_end("t3", 1'b0, 1'b1, 1'b0, 64'h000003F8_00000000, 254);

        // T4: release timing and ignored start during RUN
        @(negedge CLK);
        pc_step = 64'd4; hit_pc = 64'h140; hit_val = 64'h55;
        start_pc = 64'h100; end_pc = 64'h140; expected = 64'h55; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("t4_busy_n0", {63'd0, busy}, 64'd1);
        @(negedge CLK);
        check("t4_resetl_n1", {63'd0, proc_resetl}, 64'd0);
        @(negedge CLK);
        check("t4_resetl_n2", {63'd0, proc_resetl}, 64'd0);
        @(negedge CLK);
        check("t4_resetl_n3", {63'd0, proc_resetl}, 64'd1);
        repeat (3) @(negedge CLK);
        start_pc = 64'h8; end_pc = 64'h104; expected = 64'h99; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done("t4_done");
        check_end("t4", 1'b1, 1'b0, 1'b0, 64'h55, 16);
        check("t4_startpc", proc_startpc, 64'h100);

        // T5: end address and watchdog coincide on the 255th RUN cycle
        do_start(64'h0, 64'h3F8, 64'h77, 64'd4, 64'h3F8, 64'h77);
        wait_done("t5_done");
        check_end("t5", 1'b1, 1'b0, 1'b0, 64'h77, 254);

        // T6: PC stuck at 0x20 below end_pc
        do_start(64'h20, 64'h58, 64'h0, 64'd0, '1, 64'h0);
        wait_done("t6_done");
`ifdef PC_STALL_DETECT_EN
        check_end("t6", 1'b0, 1'b0, 1'b1, 64'h00000020_00000000, 4);
`else
        check_end("t6", 1'b0, 1'b1, 1'b0, 64'h00000020_00000000, 254);
`endif

        // T5b: reset in the middle of a run clears everything at the next edge
        do_start(64'h0, 64'h10000, 64'h0, 64'd4, '1, 64'h0);
        repeat (10) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("rst2_resetl", {63'd0, proc_resetl}, 64'd0);
        check("rst2_startpc", proc_startpc, 64'h0);
        check("rst2_busy", {63'd0, busy}, 64'd0);
        check("rst2_done", {63'd0, done}, 64'd0);
        check("rst2_cycles", {48'd0, cycle_count}, 64'd0);
        check("rst2_result", result, 64'h0);

        // T7: end_pc below start_pc terminates on the first RUN cycle
        do_start(64'h80, 64'h40, 64'h00000080_00000000, 64'd4, '1, 64'h0);
        wait_done("t7_done");
        check_end("t7", 1'b1, 1'b0, 1'b0, 64'h00000080_00000000, 0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
